// File: rtl/fp16_reduce_stream.sv
// Streaming FP16 row reducer: N masked lanes -> pipelined binary adder tree -> credit-protected
// output FIFO with tile tagging and an end-of-run done pulse.

module fp16_add_wrapper #(
    parameter int LAT = 11
) (
    input  logic        clk,
    input  logic [15:0] i_a,
    input  logic [15:0] i_b,
    output logic [15:0] o_sum
);

    // Round-to-nearest-even FP16 add; subnormals handled, NaN/Inf operands pass the larger through.
    function automatic logic [15:0] fp16_add(input logic [15:0] a, input logic [15:0] b);
        logic [15:0] x, y, res;
        logic [4:0]  ex, ey, d;
        logic [13:0] mx, my;
        logic [14:0] s;
        logic [5:0]  e;
        logic [11:0] m;
        logic        rnd;
        if (a[14:0] >= b[14:0]) begin x = a; y = b; end
        else begin x = b; y = a; end
        ex = (x[14:10] == 5'd0) ? 5'd1 : x[14:10];
        ey = (y[14:10] == 5'd0) ? 5'd1 : y[14:10];
        mx = {(x[14:10] != 5'd0), x[9:0], 3'b000};
        my = {(y[14:10] != 5'd0), y[9:0], 3'b000};
        d  = ex - ey;
        for (int i = 0; i < 14; i++) begin
            if (5'(i) < d) my = {1'b0, my[13:2], my[1] | my[0]};
        end
        if (x[15] == y[15]) s = {1'b0, mx} + {1'b0, my};
        else                s = {1'b0, mx} - {1'b0, my};
        e = {1'b0, ex};
        if (s[14]) begin
            s = {1'b0, s[14:2], s[1] | s[0]};
            e = e + 6'd1;
        end else begin
            for (int i = 0; i < 13; i++) begin
                if (!s[13] && (e > 6'd1)) begin
                    s = {s[13:0], 1'b0};
                    e = e - 6'd1;
                end
            end
        end
        rnd = s[2] & (s[3] | s[1] | s[0]);
        m   = {1'b0, s[13:3]} + {11'd0, rnd};
        if (m[11]) begin
            m = {1'b0, m[11:1]};
            e = e + 6'd1;
        end
        if (x[14:10] == 5'd31)  res = x;
        else if (m == 12'd0)    res = {x[15] & y[15], 15'd0};
        else if (e >= 6'd31)    res = {x[15], 5'd31, 10'd0};
        else                    res = {x[15], (m[10] ? e[4:0] : 5'd0), m[9:0]};
        return res;
    endfunction

    logic [15:0] r_pipe [LAT];

    // Fixed-latency adder pipeline; carries no reset, validity is tracked by the parent.
    always_ff @(posedge clk) begin
        r_pipe[0] <= fp16_add(i_a, i_b);
        for (int i = 1; i < LAT; i++) r_pipe[i] <= r_pipe[i-1];
    end

    assign o_sum = r_pipe[LAT-1];

endmodule

module fp16_reduce_stream #(
    parameter int DW         = 16,
    parameter int N          = 16,
    parameter int ADD_LAT    = 11,
    parameter int TILES      = 16,
    parameter int FIFO_DEPTH = 48
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_clear,
    input  logic                     i_in_valid,
    output logic                     o_in_ready,
    input  logic [N*DW-1:0]          i_in_data,
    input  logic [N-1:0]             i_in_mask,
    output logic                     o_out_valid,
    input  logic                     i_out_ready,
    output logic [DW-1:0]            o_out_sum,
    output logic [$clog2(TILES):0]   o_out_idx,
    output logic                     o_out_last,
    output logic                     o_done
);

    localparam int DEPTH    = $clog2(N);
    localparam int TREE_LAT = ADD_LAT * DEPTH;
    localparam int IW       = $clog2(TILES) + 1;
    localparam int AW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW       = $clog2(FIFO_DEPTH + 1) + 1;
    localparam int EW       = DW + IW + 1;

    // Heap-ordered tree: node j sums nodes 2j+1 and 2j+2, leaves N-1.. hold lanes 0..N-1.
    logic [2*N-2:0][DW-1:0] w_node;

    genvar g;
    for (g = 0; g < N; g++) begin : g_leaf
        assign w_node[N-1+g] = i_in_mask[g] ? i_in_data[g*DW +: DW] : {DW{1'b0}};
    end
    for (g = 0; g < N-1; g++) begin : g_add
        fp16_add_wrapper #(.LAT(ADD_LAT)) u_add (
            .clk   (clk),
            .i_a   (w_node[2*g+1]),
            .i_b   (w_node[2*g+2]),
            .o_sum (w_node[g])
        );
    end

    logic [TREE_LAT-1:0] r_vld;
    logic [IW-1:0]       r_tag [TREE_LAT];
    logic [IW-1:0]       r_tile;
    logic [CW-1:0]       r_inflight, r_count;
    logic [AW-1:0]       r_wr, r_rd;
    logic                r_done;
    logic [EW-1:0]       r_mem [FIFO_DEPTH];

    logic          w_accept, w_wr, w_pop;
    logic [CW-1:0] w_credits;
    logic [EW-1:0] w_head;

    assign w_credits   = r_inflight + r_count;
    assign o_in_ready  = (w_credits < CW'(FIFO_DEPTH));
    assign o_out_valid = (r_count != {CW{1'b0}});
    assign w_accept    = i_in_valid & o_in_ready;
    assign w_wr        = r_vld[TREE_LAT-1];
    assign w_pop       = o_out_valid & i_out_ready;
    assign w_head      = r_mem[r_rd];
    assign o_out_sum   = o_out_valid ? w_head[DW-1:0] : {DW{1'b0}};
    assign o_out_idx   = o_out_valid ? w_head[DW +: IW] : {IW{1'b0}};
    assign o_out_last  = o_out_valid & w_head[EW-1];
    assign o_done      = r_done;

    // Valid/tag pipelines, credit counters, FIFO pointers and done pulse; clear outranks everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld      <= {TREE_LAT{1'b0}};
            for (int i = 0; i < TREE_LAT; i++) r_tag[i] <= {IW{1'b0}};
            r_tile     <= {IW{1'b0}};
            r_inflight <= {CW{1'b0}};
            r_count    <= {CW{1'b0}};
            r_wr       <= {AW{1'b0}};
            r_rd       <= {AW{1'b0}};
            r_done     <= 1'b0;
        end else if (i_clear) begin
            r_vld      <= {TREE_LAT{1'b0}};
            for (int i = 0; i < TREE_LAT; i++) r_tag[i] <= {IW{1'b0}};
            r_tile     <= {IW{1'b0}};
            r_inflight <= {CW{1'b0}};
            r_count    <= {CW{1'b0}};
            r_wr       <= {AW{1'b0}};
            r_rd       <= {AW{1'b0}};
            r_done     <= 1'b0;
        end else begin
            r_vld    <= (r_vld << 1) | TREE_LAT'(w_accept);
            r_tag[0] <= r_tile;
            for (int i = 1; i < TREE_LAT; i++) r_tag[i] <= r_tag[i-1];
            if (w_accept) begin
                r_tile <= (r_tile == IW'(TILES-1)) ? {IW{1'b0}} : r_tile + IW'(1);
            end
            r_inflight <= r_inflight + CW'(w_accept) - CW'(w_wr);
            r_count    <= r_count + CW'(w_wr) - CW'(w_pop);
            if (w_wr) begin
                r_wr <= (r_wr == AW'(FIFO_DEPTH-1)) ? {AW{1'b0}} : r_wr + AW'(1);
            end
            if (w_pop) begin
                r_rd <= (r_rd == AW'(FIFO_DEPTH-1)) ? {AW{1'b0}} : r_rd + AW'(1);
            end
            r_done <= w_pop & w_head[EW-1];
        end
    end

    // FIFO storage; contents are never visible unless counted valid, so no reset is needed.
    always_ff @(posedge clk) begin
        if (w_wr && !i_clear) begin
            r_mem[r_wr] <= {(r_tag[TREE_LAT-1] == IW'(TILES-1)), r_tag[TREE_LAT-1], w_node[0]};
        end
    end

endmodule

// File: tb/tb_fp16_reduce_stream.sv
// Scoreboard bench for fp16_reduce_stream: lanes carry multiples of 0.5 so every partial sum is exact
// and the reference is a plain integer sum converted to FP16.

module tb_fp16_reduce_stream;

    localparam int N          = 16;
    localparam int DW         = 16;
    localparam int ADD_LAT    = 11;
    localparam int TILES      = 3;
    localparam int FIFO_DEPTH = 48;
    localparam int TREE_LAT   = ADD_LAT * $clog2(N);
    localparam int IW         = $clog2(TILES) + 1;

    logic              clk, rst_n, i_clear, i_in_valid, o_in_ready;
    logic [N*DW-1:0]   i_in_data;
    logic [N-1:0]      i_in_mask;
    logic              o_out_valid, i_out_ready, o_out_last, o_done;
    logic [DW-1:0]     o_out_sum;
    logic [IW-1:0]     o_out_idx;

    fp16_reduce_stream #(.DW(DW), .N(N), .ADD_LAT(ADD_LAT), .TILES(TILES), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .i_clear(i_clear), .i_in_valid(i_in_valid), .o_in_ready(o_in_ready),
        .i_in_data(i_in_data), .i_in_mask(i_in_mask), .o_out_valid(o_out_valid), .i_out_ready(i_out_ready),
        .o_out_sum(o_out_sum), .o_out_idx(o_out_idx), .o_out_last(o_out_last), .o_done(o_done)
    );

    typedef struct { logic [15:0] sum; int idx; logic last; } exp_t;
    exp_t sbq [$];

    int n_cmp = 0, n_bad = 0;
    int tile_m = 0, ready_mode = 1, stall_cnt = 0, n_done = 0;
    int lane_k [N];
    bit exp_done = 1'b0;

    initial begin clk = 1'b0; forever #5 clk = ~clk; end
    initial begin #2000000; $display("FAIL watchdog: simulation time limit reached"); $fatal(1); end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    // Value k/2 as FP16; sums here never exceed 11 significant bits, so this is exact.
    function automatic logic [15:0] k2fp(input int k);
        int m, p;
        logic s;
        if (k == 0) return 16'h0000;
        s = (k < 0);
        m = s ? -k : k;
        p = 0;
        while ((m >> (p + 1)) != 0) p++;
        return {s, 5'(14 + p), 10'((m << 10) >> p)};
    endfunction

    initial begin
        i_out_ready = 1'b0;
        forever begin
            @(posedge clk); #2;
            case (ready_mode)
                0:       i_out_ready = 1'b0;
                1:       i_out_ready = 1'b1;
                default: i_out_ready = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    // Monitor: compare head against the scoreboard whenever it is valid; pop on handshake.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (exp_done || o_done) check("done", 32'(o_done), 32'(exp_done));
                if (o_done) n_done++;
                exp_done = 1'b0;
                if (o_out_valid) begin
                    if (sbq.size() == 0) begin
                        check("unexpected_out", 32'(o_out_valid), 32'd0);
                    end else begin
                        e = sbq[0];
                        check("sum", 32'(o_out_sum), 32'(e.sum));
                        check("idx", 32'(o_out_idx), 32'(e.idx));
                        check("last", 32'(o_out_last), 32'(e.last));
                        if (i_out_ready && !i_clear) begin
                            void'(sbq.pop_front());
                            exp_done = e.last;
                        end
                    end
                end
            end else begin
                exp_done = 1'b0;
            end
        end
    end

    // One offer cycle: drive lane_k/mask, accept is decided by in_ready ahead of the next edge.
    task automatic offer(input logic [N-1:0] m, output bit acc);
        int s;
        exp_t e;
        s = 0;
        for (int i = 0; i < N; i++) begin
            i_in_data[i*DW +: DW] = k2fp(lane_k[i]);
            if (m[i]) s += lane_k[i];
        end
        i_in_mask  = m;
        i_in_valid = 1'b1;
        acc = 1'b0;
        @(negedge clk);
        if (o_in_ready) begin
            e.sum = k2fp(s); e.idx = tile_m; e.last = (tile_m == TILES - 1);
            sbq.push_back(e);
            tile_m = (tile_m + 1) % TILES;
            acc = 1'b1;
        end else begin
            stall_cnt++;
        end
        @(posedge clk); #1;
    endtask

    task automatic send_beat(input logic [N-1:0] m);
        bit acc;
        acc = 1'b0;
        for (int c = 0; c < 2000 && !acc; c++) offer(m, acc);
        if (!acc) check("accept_timeout", 32'(o_in_ready), 32'd1);
        i_in_valid = 1'b0;
    endtask

    task automatic rand_lanes();
        for (int i = 0; i < N; i++) lane_k[i] = $urandom_range(0, 32) - 16;
    endtask

    task automatic drain();
        for (int c = 0; c < 4000 && sbq.size() != 0; c++) @(posedge clk);
        repeat (3) @(posedge clk);
        #1;
        check("drain_left", 32'(sbq.size()), 32'd0);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_in_ready"},  32'(o_in_ready),  32'd1);
        check({tag, "_out_valid"}, 32'(o_out_valid), 32'd0);
        check({tag, "_out_sum"},   32'(o_out_sum),   32'd0);
        check({tag, "_out_idx"},   32'(o_out_idx),   32'd0);
        check({tag, "_out_last"},  32'(o_out_last),  32'd0);
        check({tag, "_done"},      32'(o_done),      32'd0);
    endtask

    task automatic quiet_window(input string name, input int cycles);
        int seen;
        seen = 0;
        repeat (cycles) begin @(negedge clk); if (o_out_valid) seen++; end
        @(posedge clk); #1;
        check(name, 32'(seen), 32'd0);
    endtask

    initial begin
        int lat, acc_n;
        bit acc;
        rst_n = 1'b0; i_clear = 1'b0; i_in_valid = 1'b0; i_in_data = '0; i_in_mask = '0;
        #1;
        check_reset_vals("reset");
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Single beat of 1.0 on all lanes: exact latency and 16.0
        ready_mode = 1;
        for (int i = 0; i < N; i++) lane_k[i] = 2;
        send_beat({N{1'b1}});
        lat = 0;
        while (!o_out_valid && lat < 200) begin @(posedge clk); #1; lat++; end
        check("latency", 32'(lat), 32'(TREE_LAT));
        check("sum_all_ones", 32'(o_out_sum), 32'h4C00);
        check("idx_first", 32'(o_out_idx), 32'd0);
        drain();
        send_beat(16'h00FF);
        send_beat(16'h0000);
        drain();

        // Back-to-back with a deep FIFO and out_ready high: in_ready must never drop
        stall_cnt = 0;
        for (int b = 0; b < 60; b++) begin rand_lanes(); send_beat(N'($urandom)); end
        check("throughput_stalls", 32'(stall_cnt), 32'd0);
        drain();

        // Backpressure: exactly FIFO_DEPTH accepts, then a pop frees one credit
        ready_mode = 0;
        acc_n = 0;
        for (int c = 0; c < FIFO_DEPTH + TREE_LAT + 10; c++) begin
            rand_lanes();
            offer(N'($urandom), acc);
            if (acc) acc_n++;
        end
        i_in_valid = 1'b0;
        check("bp_accepts", 32'(acc_n), 32'(FIFO_DEPTH));
        check("bp_in_ready_low", 32'(o_in_ready), 32'd0);
        ready_mode = 1;
        @(negedge clk);
        @(negedge clk);
        check("pop_credit", 32'(o_in_ready), 32'd1);
        @(posedge clk); #1;
        for (int b = 0; b < 10; b++) begin rand_lanes(); send_beat({N{1'b1}}); end
        drain();

        // Tile sequence after a clear: values 1.0..6.0, two done pulses
        i_clear = 1'b1; @(posedge clk); #1; i_clear = 1'b0;
        sbq.delete(); tile_m = 0; n_done = 0;
        for (int v = 1; v <= 6; v++) begin
            for (int i = 0; i < N; i++) lane_k[i] = 2 * v;
            send_beat({N{1'b1}});
        end
        drain();
        check("done_pulses", 32'(n_done), 32'd2);

        // Reset mid-flight
        rand_lanes(); send_beat({N{1'b1}});
        rand_lanes(); send_beat({N{1'b1}});
        rst_n = 1'b0;
        #1;
        check_reset_vals("midreset");
        sbq.delete(); tile_m = 0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        quiet_window("post_reset_quiet", 2 * TREE_LAT);

        // Clear coinciding with an accept while 5 beats are in flight
        for (int b = 0; b < 5; b++) begin rand_lanes(); send_beat(N'($urandom)); end
        rand_lanes();
        i_in_valid = 1'b1; i_clear = 1'b1;
        @(posedge clk); #1;
        i_clear = 1'b0; i_in_valid = 1'b0;
        sbq.delete(); tile_m = 0;
        quiet_window("post_clear_quiet", TREE_LAT + 10);
        for (int i = 0; i < N; i++) lane_k[i] = 3;
        send_beat({N{1'b1}});
        drain();

        // Randomized traffic with random backpressure and gaps
        ready_mode = 2;
        for (int b = 0; b < 200; b++) begin
            rand_lanes();
            send_beat(N'($urandom));
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end
        drain();
        ready_mode = 1;
        repeat (5) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
